// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multiply/divide unit with architectural HI/LO and a GPR product port
// Multi-cycle multiply (fixed latency) and restoring divide retiring DIV_RADIX_LOG2 quotient bits per cycle.
module ex_mdu #(
    parameter int WIDTH          = 32,
    parameter int MUL_CYCLES     = 3,
    parameter int DIV_RADIX_LOG2 = 1
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] gpr_result,
    output logic             done,
    output logic             busy
);
    localparam int ITERS   = WIDTH / DIV_RADIX_LOG2;
    localparam int CNT_MAX = (ITERS > MUL_CYCLES) ? ITERS : MUL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(ITERS - 1);

    localparam logic [3:0] OP_MULT   = 4'd1;
    localparam logic [3:0] OP_MULTU  = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_DIVU   = 4'd4;
    localparam logic [3:0] OP_MADD   = 4'd5;
    localparam logic [3:0] OP_MADDU  = 4'd6;
    localparam logic [3:0] OP_MSUB   = 4'd7;
    localparam logic [3:0] OP_MSUBU  = 4'd8;
    localparam logic [3:0] OP_MTHI   = 4'd9;
    localparam logic [3:0] OP_MTLO   = 4'd10;
    localparam logic [3:0] OP_MULGPR = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state, state_nx;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, rem_q, quo_q;
    logic [CW-1:0]      cnt;
    logic               accept, op_is_mul, op_is_div, op_is_mt, commit;
    logic               mul_signed, div_signed;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
    logic [WIDTH-1:0]   a_mag_in, b_mag, div_q_nx, div_r_nx, quo_fix, rem_fix;
    logic [WIDTH-1:0]   r_t, q_t;
    logic [WIDTH:0]     sh;

    always_comb begin
        op_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU) ||
                    (op == OP_MSUB) || (op == OP_MSUBU) || (op == OP_MULGPR);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        op_is_mt  = (op == OP_MTHI) || (op == OP_MTLO);
        accept    = in_valid && in_ready && !flush && (op_is_mul || op_is_div || op_is_mt);
        commit    = (state != S_IDLE) && !flush && (cnt == '0);
        a_mag_in  = (op == OP_DIV && src_a[WIDTH-1]) ? -src_a : src_a;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept && op_is_mul)      state_nx = S_MUL;
                else if (accept && op_is_div) state_nx = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (flush || cnt == '0) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_IDLE);
        busy     = (state != S_IDLE);
    end

    // Product is formed from the latched operands at the commit edge; sign-extending to 2*WIDTH
    // lets one unsigned multiplier serve both signed and unsigned forms.
    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB) || (op_q == OP_MULGPR);
        ext_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod       = ext_a * ext_b;
        acc        = {hi, lo};
    end

    always_comb begin
        div_signed = (op_q == OP_DIV);
        b_mag      = (div_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        r_t        = rem_q;
        q_t        = quo_q;
        sh         = '0;
        for (int i = 0; i < DIV_RADIX_LOG2; i++) begin
            sh  = {r_t, q_t[WIDTH-1]};
            q_t = {q_t[WIDTH-2:0], 1'b0};
            if (sh >= {1'b0, b_mag}) begin
                sh     = sh - {1'b0, b_mag};
                q_t[0] = 1'b1;
            end
            r_t = sh[WIDTH-1:0];
        end
        div_q_nx = q_t;
        div_r_nx = r_t;
        quo_fix  = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_q_nx : div_q_nx;
        rem_fix  = (div_signed && a_q[WIDTH-1]) ? -div_r_nx : div_r_nx;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hi <= '0; lo <= '0; gpr_result <= '0; done <= 1'b0;
            op_q <= '0; a_q <= '0; b_q <= '0; rem_q <= '0; quo_q <= '0; cnt <= '0;
        end else begin
            done <= commit || (accept && op_is_mt);
            if (accept) begin
                op_q  <= op;
                a_q   <= src_a;
                b_q   <= src_b;
                cnt   <= op_is_div ? DIV_LOAD : MUL_LOAD;
                rem_q <= '0;
                quo_q <= a_mag_in;
                if (op == OP_MTHI) hi <= src_a;
                if (op == OP_MTLO) lo <= src_a;
            end else if (state != S_IDLE && !flush) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (state == S_DIV) begin
                    rem_q <= div_r_nx;
                    quo_q <= div_q_nx;
                end
            end
            if (commit) begin
                case (op_q)
                    OP_MULT, OP_MULTU: {hi, lo} <= prod;
                    OP_MADD, OP_MADDU: {hi, lo} <= acc + prod;
                    OP_MSUB, OP_MSUBU: {hi, lo} <= acc - prod;
                    OP_MULGPR:         gpr_result <= prod[WIDTH-1:0];
                    OP_DIV, OP_DIVU: begin
                        // Zero divisor: all-ones quotient, dividend passed through as remainder.
                        if (b_q == '0) begin
                            lo <= '1;
                            hi <= a_q;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed self-checking bench for ex_mdu (WIDTH=32, MUL_CYCLES=3, radix-2 divide)
module tb_ex_mdu;
    logic        Clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, done, busy;
    logic [3:0]  op;
    logic [31:0] src_a, src_b, hi, lo, gpr_result;
    int          n_vec = 0;
    int          n_bad = 0;
    int          lat;
    logic        saw_done;

    ex_mdu #(.WIDTH(32), .MUL_CYCLES(3), .DIV_RADIX_LOG2(1)) dut (
        .Clk(Clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .hi(hi), .lo(lo), .gpr_result(gpr_result),
        .done(done), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge Clk); #1;
        in_valid = 1'b0; op = 4'd0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (done !== 1'b1 && l < 200) begin
            @(posedge Clk); #1;
            l++;
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
        repeat (3) @(posedge Clk);
        #1 reset = 1'b0;
        @(posedge Clk); #1;
        chk("rst_hilo", {hi, lo}, 64'h0);
        chk("rst_gpr", {32'h0, gpr_result}, 64'h0);
        chk("rst_flags", {61'h0, done, busy, in_ready}, 64'h1);

        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        chk("mult_busy", {63'h0, busy}, 64'h1);
        wait_done(lat);
        chk("mult_lat", lat, 3);
        chk("mult", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        issue(4'd2, 32'hFFFFFFFE, 32'd3); wait_done(lat);
        chk("multu", {hi, lo}, 64'h00000002_FFFFFFFA);

        issue(4'd3, 32'hFFFFFFF9, 32'd2); wait_done(lat);
        chk("div_lat", lat, 32);
        chk("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(4'd3, 32'd7, 32'hFFFFFFFE); wait_done(lat);
        chk("div_7_neg2", {hi, lo}, 64'h00000001_FFFFFFFD);
        issue(4'd4, 32'd100, 32'd7); wait_done(lat);
        chk("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
        issue(4'd4, 32'd7, 32'd0); wait_done(lat);
        chk("divu_by0", {hi, lo}, 64'h00000007_FFFFFFFF);
        issue(4'd3, 32'hFFFFFFF9, 32'd0); wait_done(lat);
        chk("div_by0", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF); wait_done(lat);
        chk("div_min_m1", {hi, lo}, 64'h00000000_80000000);

        // MTHI, MTLO, MADDU issued on consecutive cycles, then MSUB while done is high
        in_valid = 1'b1; op = 4'd9; src_a = 32'd5;
        @(posedge Clk); #1;
        chk("mthi", {32'h0, hi}, 64'h5);
        chk("mthi_done", {63'h0, done}, 64'h1);
        op = 4'd10; src_a = 32'd1;
        @(posedge Clk); #1;
        op = 4'd6; src_a = 32'd2; src_b = 32'd3;
        @(posedge Clk); #1;
        in_valid = 1'b0; op = 4'd0;
        wait_done(lat);
        chk("maddu", {hi, lo}, 64'h00000005_00000007);
        issue(4'd7, 32'd1, 32'd8);
        chk("msub_acc", {63'h0, busy}, 64'h1);
        wait_done(lat);
        chk("msub", {hi, lo}, 64'h00000004_FFFFFFFF);

        issue(4'd4, 32'd100, 32'd7);
        repeat (10) @(posedge Clk);
        #1 flush = 1'b1;
        @(posedge Clk); #1 flush = 1'b0;
        chk("flush_busy", {62'h0, busy, done}, 64'h0);
        chk("flush_hold", {hi, lo}, 64'h00000004_FFFFFFFF);
        issue(4'd1, 32'd6, 32'd7); wait_done(lat);
        chk("post_flush_lat", lat, 3);
        chk("post_flush_mult", {hi, lo}, 64'h00000000_0000002A);

        issue(4'd1, 32'd2, 32'd3);
        repeat (2) @(posedge Clk);
        #1 flush = 1'b1;
        @(posedge Clk); #1 flush = 1'b0;
        saw_done = done;
        @(posedge Clk); #1 saw_done = saw_done | done;
        chk("flush_commit", {62'h0, busy, saw_done}, 64'h0);
        chk("flush_commit_hold", {hi, lo}, 64'h00000000_0000002A);

        flush = 1'b1; in_valid = 1'b1; op = 4'd9; src_a = 32'd9;
        @(posedge Clk); #1;
        flush = 1'b0; in_valid = 1'b0; op = 4'd0;
        chk("flush_idle", {31'h0, done, hi}, 64'h0);

        issue(4'd0, 32'd1, 32'd1);
        saw_done = done | busy;
        issue(4'd12, 32'd1, 32'd1);
        saw_done = saw_done | done | busy;
        chk("nop", {63'h0, saw_done}, 64'h0);

        issue(4'd1, 32'd3, 32'd3);
        in_valid = 1'b1; op = 4'd10; src_a = 32'd55;
        @(posedge Clk); #1;
        in_valid = 1'b0; op = 4'd0;
        wait_done(lat);
        chk("busy_ignore_lat", lat, 2);
        chk("busy_ignore", {hi, lo}, 64'h00000000_00000009);

        issue(4'd11, 32'd3, 32'hFFFFFFFB); wait_done(lat);
        chk("mulgpr", {32'h0, gpr_result}, 64'hFFFFFFF1);
        chk("mulgpr_hilo", {hi, lo}, 64'h00000000_00000009);

        issue(4'd9, 32'h1234, 32'd0);
        issue(4'd1, 32'd2, 32'd3);
        @(posedge Clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_regs", {hi, lo}, 64'h0);
        chk("rst_mid_gpr", {31'h0, busy, gpr_result}, 64'h0);
        @(posedge Clk); #1 reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1 saw_done = saw_done | done;
        end
        chk("rst_no_done", {63'h0, saw_done}, 64'h0);
        issue(4'd11, 32'h00010000, 32'h00010000); wait_done(lat);
        chk("mulgpr_wrap", {hi, lo}, 64'h0);
        chk("mulgpr_wrap_gpr", {31'h0, done, gpr_result}, 64'h1_00000000);

        issue(4'd5, 32'hFFFFFFFF, 32'd1); wait_done(lat);
        chk("madd", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done(lat);
        chk("msubu", {hi, lo}, 64'h00000001_FFFFFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI, LO and result width.
REQ-002 Parameter MUL_CYCLES, default 3 (legal 1..8): cycles from multiply accept to done.
REQ-003 Parameter DIV_RADIX_LOG2, default 1 (1 or 2): quotient bits retired per divide cycle; WIDTH divisible by it.
REQ-004 Clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 flush  in  1  abort in-flight op (exception/pipeline flush).
REQ-007 in_valid  in  1  op request.
REQ-008 in_ready  out  1  unit can accept a request this cycle.
REQ-009 op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11 MULGPR; 12-15 treated as NOP.
REQ-010 src_a  in  WIDTH  rs operand.
REQ-011 src_b  in  WIDTH  rt operand.
REQ-012 hi  out  WIDTH  architectural HI register.
REQ-013 lo  out  WIDTH  architectural LO register.
REQ-014 gpr_result  out  WIDTH  low WIDTH bits of the MULGPR product; holds until next MULGPR done.
REQ-015 done  out  1  one-cycle pulse: op completed, results visible.
REQ-016 busy  out  1  multi-cycle op in flight (stall source for the execute stage).

Function
REQ-017 Accept = in_valid & in_ready & !flush & op in 1..11; in_ready = (state==IDLE); NOP is never accepted and has no effect.
REQ-018 States: IDLE, MUL, DIV; busy = (state!=IDLE).
REQ-019 MULT/MULTU/MADD*/MSUB*/MULGPR: accept moves IDLE->MUL, operands and op latched, counter loaded with MUL_CYCLES-1; counter decrements each MUL cycle; at 0 results commit and state returns to IDLE on the same edge, done high the following cycle; accept-to-done latency = MUL_CYCLES cycles.
REQ-020 MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
REQ-021 MADD/MADDU: {hi,lo} += product; MSUB/MSUBU: {hi,lo} -= product; 2*WIDTH-bit modulo arithmetic, using {hi,lo} as of commit.
REQ-022 MULGPR: gpr_result = low WIDTH bits of signed product; hi/lo unchanged.
REQ-023 DIV/DIVU: IDLE->DIV; WIDTH/(2^DIV_RADIX_LOG2 ... i.e. WIDTH/DIV_RADIX_LOG2) iteration cycles of restoring division on magnitudes; sign fix-up within last cycle; commit lo=quotient, hi=remainder; done next cycle.
REQ-024 Signed divide: quotient truncates toward zero; remainder takes dividend sign.
REQ-025 Divide by zero: no exception; lo = all ones, hi = src_a (unsigned and signed alike).
REQ-026 Signed MIN / -1: lo = MIN, hi = 0, no overflow flag.
REQ-027 MTHI/MTLO: accepted in IDLE, hi (resp. lo) = src_a on the accept edge, state stays IDLE, done pulses next cycle.
REQ-028 Back-to-back: new op accepted the cycle after commit (while done is high); MADD/MSUB must see HI/LO of the previous op.
REQ-029 flush while busy: state -> IDLE next edge, hi/lo/gpr_result unchanged, no done pulse for the aborted op.
REQ-030 flush coinciding with commit edge: flush wins; no commit, no done.
REQ-031 flush with in_valid in IDLE: request ignored.
REQ-032 flush on the cycle a done pulse is already high: pulse not suppressed (commit already occurred).
REQ-033 in_valid while busy: ignored, no queuing; requester holds.

Reset
REQ-034 reset asynchronously forces state=IDLE, hi=0, lo=0, gpr_result=0, done=0, busy=0, counters cleared; in_ready=1 after deassertion.
REQ-035 reset mid-operation discards the op; no done pulse after reset releases.

Verification
REQ-036 MULT a=0xFFFFFFFE(-2), b=3 -> after 3 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-037 DIV a=-7, b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1), done after 32 cycles (radix-2); DIVU a=7,b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-038 MTHI 5, MTLO 1, MADDU a=2,b=3 back-to-back -> hi=5, lo=7; then MSUB a=1,b=8 -> hi=4, lo=0xFFFFFFFF.
REQ-039 DIV started, flush at iteration 10 -> busy low next cycle, hi/lo hold prior values, no done; new MULT accepted next cycle completes normally.
REQ-040 Assert reset during MUL cycle 2 -> hi=lo=gpr_result=0 immediately, no done; MULGPR a=0x10000,b=0x10000 after release -> gpr_result=0, hi/lo unchanged.
REQ-041 Random ops against a reference model across WIDTH=16/32 and DIV_RADIX_LOG2=1/2, including DIV MIN/-1 -> lo=MIN, hi=0.
